// File: rtl/hilo_unit.sv
// HI/LO result stage for the 16x16 unsigned array multiplier: registers operands,
// waits LAT cycles for the product to settle, then captures it into HI/LO.
module hilo_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Next-state: start beats move-to in IDLE; capture on the last WAIT cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mul_a_d = a;
                    mul_b_d = b;
                    cnt_d   = CNT_W'(LAT);
                    state_d = ST_WAIT;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = mul_hi;
                    lo_d    = mul_lo;
                    ovf_d   = (mul_hi != '0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign ovf   = ovf_q;
    assign done  = done_q;
    assign busy  = (state_q == ST_WAIT);

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a behavioural multiplier on mul_a/mul_b.
module tb_hilo_unit;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned LAT   = 2;

    logic             clk = 1'b0;
    logic             reset, start, mthi, mtlo;
    logic [WIDTH-1:0] a, b, wdata;
    logic [WIDTH-1:0] mul_a, mul_b, mul_hi, mul_lo, hi, lo;
    logic             ovf, busy, done;
    logic [31:0]      prod;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign prod = 32'(mul_a) * 32'(mul_b);
    assign mul_hi = prod[31:16];
    assign mul_lo = prod[15:0];

    hilo_unit #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_hi(mul_hi), .mul_lo(mul_lo),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi), .lo(lo), .ovf(ovf), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one multiply and check busy window, done pulse and results
    task automatic run_mul(input logic [15:0] xa, input logic [15:0] xb,
                           input logic [15:0] ehi, input logic [15:0] elo, input logic eovf);
        @(negedge clk);
        start = 1'b1; a = xa; b = xb;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(LAT); i++) begin
            if (i > 0) @(negedge clk);
            check("busy_window", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
        end
        @(negedge clk);
        check("busy_end", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("hi", 32'(hi), 32'(ehi));
        check("lo", 32'(lo), 32'(elo));
        check("ovf", 32'(ovf), 32'(eovf));
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", 32'(hi), 32'd0);
        check("rst_lo", 32'(lo), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        reset = 1'b0;

        run_mul(16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b1);
        check("mul_a_hold", 32'(mul_a), 32'h1234);
        check("mul_b_hold", 32'(mul_b), 32'h5678);
        run_mul(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b1);

        // Move-to both halves; ovf retained, no done
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 16'hBEEF;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_hi", 32'(hi), 32'hBEEF);
        check("mt_lo", 32'(lo), 32'hBEEF);
        check("mt_done", 32'(done), 32'd0);
        check("mt_ovf", 32'(ovf), 32'd1);
        check("mt_busy", 32'(busy), 32'd0);

        run_mul(16'h00FF, 16'h0100, 16'h0000, 16'hFF00, 1'b0);

        // start and mthi during WAIT are ignored
        @(negedge clk);
        start = 1'b1; a = 16'd5; b = 16'd7;
        @(negedge clk);
        start = 1'b1; a = 16'd3; b = 16'd4; mthi = 1'b1; wdata = 16'hAAAA;
        check("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("ign_mthi", 32'(hi), 32'd0);
        check("ign_mul_a", 32'(mul_a), 32'd5);
        @(negedge clk);
        check("ign_done", 32'(done), 32'd1);
        check("ign_hi", 32'(hi), 32'd0);
        check("ign_lo", 32'(lo), 32'h0023);
        @(negedge clk);
        check("ign_no_busy", 32'(busy), 32'd0);
        check("ign_one_done", 32'(done), 32'd0);

        // start beats mtlo in IDLE
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 16'hBEEF;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        start = 1'b1; mtlo = 1'b1; wdata = 16'h1111; a = 16'd2; b = 16'd3;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        check("pri_busy", 32'(busy), 32'd1);
        check("pri_lo_kept", 32'(lo), 32'hBEEF);
        @(negedge clk);
        @(negedge clk);
        check("pri_done", 32'(done), 32'd1);
        check("pri_lo", 32'(lo), 32'd6);
        check("pri_hi", 32'(hi), 32'd0);

        // Reset one cycle after start aborts the multiply
        @(negedge clk);
        start = 1'b1; a = 16'd9; b = 16'd9;
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", 32'(hi), 32'd0);
        check("abort_lo", 32'(lo), 32'd0);
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        run_mul(16'd9, 16'd9, 16'h0000, 16'h0051, 1'b0);

        // start held high: one multiply every LAT+1 cycles
        @(negedge clk);
        start = 1'b1; a = 16'd1; b = 16'd1;
        ndone = 0;
        for (int i = 0; i < 2 * (int'(LAT) + 1); i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        start = 1'b0;
        check("b2b_dones", 32'(ndone), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequencing and result-holding stage downstream of the 16x16 unsigned array multiplier. It registers the operands that drive the multiplier and waits a fixed number of cycles for the combinational product to settle. It then captures the 32-bit product into architectural HI/LO registers with a start/busy/done handshake. It also supports direct HI/LO writes (move-to-HI/LO) for the datapath and exposes an overflow flag (product wider than 16 bits).

## Interface

- `WIDTH`, 16: operand width; HI and LO are each `WIDTH` bits.
- `LAT`, 2: cycles allowed for the multiplier to settle; legal range 1..15.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply of `a` × `b`; sampled only in IDLE.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `mul_a`  out  WIDTH  registered operand driving the multiplier's A input.
- `mul_b`  out  WIDTH  registered operand driving the multiplier's B input.
- `mul_hi`  in  WIDTH  upper product half returned by the multiplier.
- `mul_lo`  in  WIDTH  lower product half returned by the multiplier.
- `mthi`  in  1  write `wdata` into HI; honoured only in IDLE.
- `mtlo`  in  1  write `wdata` into LO; honoured only in IDLE.
- `wdata`  in  WIDTH  data for `mthi` / `mtlo`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `ovf`  out  1  registered flag: 1 when the last multiply produced HI ≠ 0.
- `busy`  out  1  multiply in flight.
- `done`  out  1  one-cycle pulse: HI/LO were just updated by a multiply.

## Operation

- States: IDLE and WAIT. A 4-bit down-counter `cnt` tracks time in WAIT.
- **IDLE, `start` = 1:**
  - `mul_a <= a`, `mul_b <= b`, `cnt <= LAT`, go to WAIT.
  - `mthi` / `mtlo` in the same cycle are dropped (`start` has priority).
- **IDLE, `start` = 0:**
  - `mthi` loads `hi <= wdata`; `mtlo` loads `lo <= wdata`; both may be set together.
  - A move-to does not alter `ovf` and does not pulse `done`.
- **WAIT:**
  - `cnt` decrements each cycle. `start`, `mthi` and `mtlo` are ignored.
  - When `cnt` = 1: `hi <= mul_hi`, `lo <= mul_lo`, `ovf <= (mul_hi != 0)`, `done <= 1`, go to IDLE.
- **Operand hold:** `mul_a` / `mul_b` hold their values after the capture until the next accepted `start`. The multiplier output therefore stays stable.
- **Arithmetic:** unsigned only; product = {`mul_hi`, `mul_lo`}. No sign handling or truncation in this block.
- **Outputs:** `busy` = (state == WAIT), decoded from the state register. `done` is a register, cleared every cycle it is not set.

## Timing

- **Reset values:** state IDLE; `cnt`, `mul_a`, `mul_b`, `hi`, `lo` = 0; `ovf`, `done`, `busy` = 0.
- **Reset mid-operation:** aborts with no HI/LO write, and `done` stays 0.
- **Handshake:** `start` sampled at edge t. Then:
  - `busy` = 1 from edge t to edge t+LAT.
  - `hi`, `lo`, `ovf` update and `done` = 1 after edge t+LAT.
  - Latency is exactly `LAT` cycles.
- **Back-to-back:** `start` held high gives one multiply every `LAT`+1 cycles. A new `start` is accepted in the cycle `done` is high. A `start` asserted while `busy` is lost, not queued; the caller must wait for `busy` = 0.
- **Settle window:** `mul_hi` / `mul_lo` are sampled only at edge t+LAT, so the multiplier has `LAT` full cycles to settle. With `LAT` = 1 the product must settle in a single cycle.
- **Move-to timing:** `mthi` / `mtlo` take effect at the next edge; read-after-write shows the new value one cycle later.

## Test plan

- **Reset:** after reset, `hi` = `lo` = 0, `busy` = `done` = `ovf` = 0; `mul_a` = `mul_b` = 0.
- **Basic multiply** (bench has a behavioural multiplier on `mul_a` / `mul_b`, `LAT` = 2):
  - `start` with `a` = 0x1234, `b` = 0x5678.
  - `busy` for 2 cycles, then `done` pulse; `hi` = 0x0626, `lo` = 0x0060, `ovf` = 1.
- **Maximum operands and overflow clear:**
  - 0xFFFF × 0xFFFF gives `hi` = 0xFFFE, `lo` = 0x0001, `ovf` = 1.
  - Then 0x00FF × 0x0100 gives `hi` = 0x0000, `lo` = 0xFF00, `ovf` = 0.
- **Ignored requests while busy:**
  - `start` (3 × 4) and `mthi` with `wdata` = 0xAAAA, both during WAIT of a 5 × 7 multiply.
  - Result: `hi` = 0, `lo` = 0x0023, exactly one `done`, no second `busy` period.
- **Move-to and priority in IDLE:**
  - `mthi` + `mtlo` with `wdata` = 0xBEEF gives `hi` = `lo` = 0xBEEF, no `done`.
  - `start` + `mtlo` in the same cycle: `mtlo` dropped, multiply proceeds.
- **Reset mid-operation:**
  - Assert `reset` one cycle after `start` (9 × 9).
  - `busy` = 0 next cycle, `hi` = `lo` = 0, no `done`.
  - A following `start` of 9 × 9 completes with `lo` = 0x0051.
